// File: rtl/data_path_param.sv
// Parametrised CPU datapath with a handshaked read/write memory access unit.
// Define DP_SHIFT_EN to turn ALU ops 110/111 into SHL/SHR; otherwise they are XOR/pass.
module data_path_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int NREG   = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      IR_Load,
  input  logic                      MAR_Load,
  input  logic                      PC_Load,
  input  logic                      PC_Inc,
  input  logic                      Reg_Load,
  input  logic [$clog2(NREG)-1:0]   Reg_Wsel,
  input  logic [$clog2(NREG)-1:0]   Bus1_Rsel,
  input  logic [$clog2(NREG)-1:0]   ALU_Bsel,
  input  logic [1:0]                Bus1_Sel,
  input  logic [1:0]                Bus2_Sel,
  input  logic [2:0]                ALU_Sel,
  input  logic                      CCR_Load,
  input  logic                      mem_rd_start,
  input  logic                      mem_wr_start,
  input  logic                      mem_ready,
  input  logic [DATA_W-1:0]         from_memory,
  output logic [ADDR_W-1:0]         address,
  output logic [DATA_W-1:0]         to_memory,
  output logic                      mem_rd,
  output logic                      mem_wr,
  output logic                      busy,
  output logic                      mem_done,
  output logic [DATA_W-1:0]         IR,
  output logic [3:0]                CCR_Result
);

  localparam int RSEL_W = $clog2(NREG);
  localparam logic [ADDR_W-1:0] ONE_A = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W:0]   ONE_D = {{DATA_W{1'b0}}, 1'b1};
  localparam int MSB = DATA_W - 1;

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   pc;
  logic [ADDR_W-1:0]   mar;
  logic [DATA_W-1:0]   mdr;
  logic [DATA_W-1:0]   wdr;
  logic [DATA_W-1:0]   rf [NREG];

  logic [DATA_W-1:0]   pc_d;
  logic [DATA_W-1:0]   mar_d;
  logic [ADDR_W-1:0]   bus2_a;
  logic [DATA_W-1:0]   bus1;
  logic [DATA_W-1:0]   bus2;
  logic [DATA_W-1:0]   in1;
  logic [DATA_W-1:0]   alu_res;
  logic [DATA_W:0]     sum;
  logic                flag_v;
  logic                flag_c;
  logic [3:0]          nzvc;

  assign address   = mar;
  assign to_memory = wdr;

  // Address-width values onto data-width buses: zero-extend or keep LSBs.
  generate
    if (ADDR_W >= DATA_W) begin : g_a_wide
      assign pc_d   = pc[DATA_W-1:0];
      assign mar_d  = mar[DATA_W-1:0];
      assign bus2_a = {{(ADDR_W-DATA_W){1'b0}}, bus2};
    end else begin : g_a_narrow
      assign pc_d   = {{(DATA_W-ADDR_W){1'b0}}, pc};
      assign mar_d  = {{(DATA_W-ADDR_W){1'b0}}, mar};
      assign bus2_a = bus2[ADDR_W-1:0];
    end
  endgenerate

  always_comb begin
    bus1 = pc_d;
    unique case (Bus1_Sel)
      2'b00: bus1 = pc_d;
      2'b01: bus1 = rf[Bus1_Rsel];
      2'b10: bus1 = mar_d;
      2'b11: bus1 = mdr;
    endcase
  end

  always_comb begin
    bus2 = alu_res;
    unique case (Bus2_Sel)
      2'b00: bus2 = alu_res;
      2'b01: bus2 = bus1;
      2'b10: bus2 = mdr;
      2'b11: bus2 = from_memory;
    endcase
  end

  assign in1 = rf[ALU_Bsel];

  always_comb begin
    sum     = '0;
    alu_res = '0;
    flag_v  = 1'b0;
    flag_c  = 1'b0;
    unique case (ALU_Sel)
      3'b000: begin
        sum     = {1'b0, in1} + {1'b0, bus1};
        alu_res = sum[DATA_W-1:0];
        flag_c  = sum[DATA_W];
        flag_v  = (in1[MSB] == bus1[MSB]) && (alu_res[MSB] != in1[MSB]);
      end
      3'b001: begin
        sum     = {1'b0, in1} - {1'b0, bus1};
        alu_res = sum[DATA_W-1:0];
        flag_c  = sum[DATA_W];
        flag_v  = (in1[MSB] != bus1[MSB]) && (alu_res[MSB] != in1[MSB]);
      end
      3'b010: alu_res = in1 & bus1;
      3'b011: alu_res = in1 | bus1;
      3'b100: begin
        sum     = {1'b0, bus1} + ONE_D;
        alu_res = sum[DATA_W-1:0];
        flag_c  = sum[DATA_W];
        flag_v  = !bus1[MSB] && alu_res[MSB];
      end
      3'b101: begin
        sum     = {1'b0, bus1} - ONE_D;
        alu_res = sum[DATA_W-1:0];
        flag_c  = sum[DATA_W];
        flag_v  = bus1[MSB] && !alu_res[MSB];
      end
`ifdef DP_SHIFT_EN
      3'b110: begin
        alu_res = {bus1[DATA_W-2:0], 1'b0};
        flag_c  = bus1[MSB];
      end
      3'b111: begin
        alu_res = {1'b0, bus1[DATA_W-1:1]};
        flag_c  = bus1[0];
      end
`else
      3'b110: alu_res = in1 ^ bus1;
      3'b111: alu_res = bus1;
`endif
    endcase
  end

  assign nzvc = {alu_res[MSB], alu_res == '0, flag_v, flag_c};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc         <= '0;
      IR         <= '0;
      mar        <= '0;
      CCR_Result <= '0;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      if (IR_Load) IR <= bus2;
      // Address must stay stable for the whole access.
      if (MAR_Load && !busy) mar <= bus2_a;
      if (PC_Load) pc <= bus2_a;
      else if (PC_Inc) pc <= pc + ONE_A;
      if (Reg_Load) rf[Reg_Wsel] <= bus2;
      if (CCR_Load) CCR_Result <= nzvc;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      mem_rd   <= 1'b0;
      mem_wr   <= 1'b0;
      busy     <= 1'b0;
      mem_done <= 1'b0;
      mdr      <= '0;
      wdr      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_rd_start) begin
            state  <= RD;
            mem_rd <= 1'b1;
            busy   <= 1'b1;
          end else if (mem_wr_start) begin
            wdr    <= bus1;
            state  <= WR;
            mem_wr <= 1'b1;
            busy   <= 1'b1;
          end
        end
        RD: begin
          if (mem_ready) begin
            mdr      <= from_memory;
            state    <= DONE;
            mem_rd   <= 1'b0;
            busy     <= 1'b0;
            mem_done <= 1'b1;
          end
        end
        WR: begin
          if (mem_ready) begin
            state    <= DONE;
            mem_wr   <= 1'b0;
            busy     <= 1'b0;
            mem_done <= 1'b1;
          end
        end
        DONE: begin
          mem_done <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic unused_rsel;
  assign unused_rsel = ^RSEL_W;

endmodule
